seven_seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a multi-digit common-segment 7-segment display. It shares one registered hex-to-segment decoder across NUM_DIGITS digits by stepping through the digits in fixed time slots, with a blanking guard at the start of each slot. It holds the displayed values in a shadow register that is committed only at frame boundaries, so a digit is never shown with a partially updated value. It sits between the value-producing logic (counters, UART debug and similar) and the board's segment and digit-select pins.

---
 rtl/seven_seg_pkg.sv | 24 ++
 rtl/seg7_hex_decode.sv | 25 ++
 rtl/seven_seg_scan_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants for the 7-segment scan controller: segment encodings,
// segment bit positions and the per-slot scan state.
package seven_seg_pkg;

    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    // Active-high segment patterns for hex digits 0..F, bit6=A down to bit0=G.
    localparam logic [6:0] SEG_LUT [0:15] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_e;

endpackage

// File: rtl/seg7_hex_decode.sv
// Registered hex-nibble to 7-segment lookup; one clock of latency,
// output cleared by reset.
module seg7_hex_decode
    import seven_seg_pkg::*;
(
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [3:0] nibble,
    output logic [6:0] segments
);

    logic [6:0] seg_r;

    // Segment pattern register
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            seg_r <= 7'h00;
        end else begin
            seg_r <= SEG_LUT[nibble];
        end
    end

    assign segments = seg_r;

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with per-slot blanking and a
// frame-synchronous shadow register for the displayed values.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int CLKS_PER_DIGIT = 25000,
    parameter int BLANK_CYCLES   = 2
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst,
    input  logic [4*NUM_DIGITS-1:0] i_Digits,
    input  logic [NUM_DIGITS-1:0]   i_Digit_En,
    input  logic                    i_Load,
    output logic [6:0]              o_Segments,
    output logic [NUM_DIGITS-1:0]   o_Digit_Sel,
    output logic                    o_Frame_Done
);

    localparam int CNT_W = (CLKS_PER_DIGIT > 1) ? $clog2(CLKS_PER_DIGIT) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int VAL_W = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(CLKS_PER_DIGIT - 1);
    localparam logic [CNT_W-1:0]      CNT_SHOW = CNT_W'(BLANK_CYCLES);
    localparam logic [CNT_W-1:0]      CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [IDX_W-1:0]      IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0]      IDX_ONE  = IDX_W'(1);
    localparam logic [NUM_DIGITS-1:0] SEL_ONE  = {{(NUM_DIGITS-1){1'b0}}, 1'b1};
    localparam logic [NUM_DIGITS-1:0] SEL_NONE = {NUM_DIGITS{1'b0}};

    logic [CNT_W-1:0]      cnt_r;
    logic [IDX_W-1:0]      idx_r;
    scan_state_e           state_r;
    logic [VAL_W-1:0]      pend_val_r;
    logic [NUM_DIGITS-1:0] pend_en_r;
    logic                  pend_vld_r;
    logic [VAL_W-1:0]      act_val_r;
    logic [NUM_DIGITS-1:0] act_en_r;
    logic [NUM_DIGITS-1:0] sel_r;
    logic                  gate_r;
    logic                  frame_done_r;

    logic [CNT_W-1:0]      cnt_nxt_s;
    logic [IDX_W-1:0]      idx_nxt_s;
    scan_state_e           state_nxt_s;
    logic                  slot_end_s;
    logic                  frame_wrap_s;
    logic [VAL_W-1:0]      pend_val_nxt_s;
    logic [NUM_DIGITS-1:0] pend_en_nxt_s;
    logic                  pend_vld_nxt_s;
    logic [VAL_W-1:0]      act_val_nxt_s;
    logic [NUM_DIGITS-1:0] act_en_nxt_s;
    logic [NUM_DIGITS-1:0] sel_nxt_s;
    logic                  gate_nxt_s;
    logic                  frame_done_nxt_s;
    logic [3:0]            nibble_s;
    logic [6:0]            dec_seg_s;

    // Slot counter and digit index advance
    always_comb begin
        slot_end_s   = (cnt_r == CNT_LAST);
        frame_wrap_s = slot_end_s && (idx_r == IDX_LAST);
        cnt_nxt_s    = cnt_r + CNT_ONE;
        idx_nxt_s    = idx_r;
        if (slot_end_s) begin
            cnt_nxt_s = CNT_ZERO;
            if (idx_r == IDX_LAST) begin
                idx_nxt_s = IDX_ZERO;
            end else begin
                idx_nxt_s = idx_r + IDX_ONE;
            end
        end else begin
            idx_nxt_s = idx_r;
        end
    end

    // Per-slot BLANK/SHOW next-state
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            BLANK: begin
                if (cnt_nxt_s == CNT_SHOW) begin
                    state_nxt_s = SHOW;
                end else begin
                    state_nxt_s = BLANK;
                end
            end
            SHOW: begin
                if (cnt_nxt_s == CNT_ZERO) begin
                    state_nxt_s = BLANK;
                end else begin
                    state_nxt_s = SHOW;
                end
            end
            default: state_nxt_s = BLANK;
        endcase
    end

    // Pending capture and frame-boundary commit; a load on the wrap edge bypasses pending
    always_comb begin
        pend_val_nxt_s = pend_val_r;
        pend_en_nxt_s  = pend_en_r;
        pend_vld_nxt_s = pend_vld_r;
        act_val_nxt_s  = act_val_r;
        act_en_nxt_s   = act_en_r;
        if (frame_wrap_s) begin
            if (i_Load) begin
                act_val_nxt_s  = i_Digits;
                act_en_nxt_s   = i_Digit_En;
                pend_vld_nxt_s = 1'b0;
            end else if (pend_vld_r) begin
                act_val_nxt_s  = pend_val_r;
                act_en_nxt_s   = pend_en_r;
                pend_vld_nxt_s = 1'b0;
            end else begin
                pend_vld_nxt_s = 1'b0;
            end
        end else if (i_Load) begin
            pend_val_nxt_s = i_Digits;
            pend_en_nxt_s  = i_Digit_En;
            pend_vld_nxt_s = 1'b1;
        end else begin
            pend_vld_nxt_s = pend_vld_r;
        end
    end

    // Next-cycle output values so the pins come straight from flops
    always_comb begin
        sel_nxt_s        = SEL_NONE;
        gate_nxt_s       = 1'b0;
        frame_done_nxt_s = (idx_nxt_s == IDX_LAST) && (cnt_nxt_s == CNT_LAST);
        if (state_nxt_s == SHOW) begin
            sel_nxt_s  = SEL_ONE << idx_nxt_s;
            gate_nxt_s = act_en_nxt_s[idx_nxt_s];
        end else begin
            sel_nxt_s  = SEL_NONE;
            gate_nxt_s = 1'b0;
        end
    end

    // Scan state, value registers and output registers
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            cnt_r        <= CNT_ZERO;
            idx_r        <= IDX_ZERO;
            state_r      <= BLANK;
            pend_val_r   <= {VAL_W{1'b0}};
            pend_en_r    <= SEL_NONE;
            pend_vld_r   <= 1'b0;
            act_val_r    <= {VAL_W{1'b0}};
            act_en_r     <= SEL_NONE;
            sel_r        <= SEL_NONE;
            gate_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            cnt_r        <= cnt_nxt_s;
            idx_r        <= idx_nxt_s;
            state_r      <= state_nxt_s;
            pend_val_r   <= pend_val_nxt_s;
            pend_en_r    <= pend_en_nxt_s;
            pend_vld_r   <= pend_vld_nxt_s;
            act_val_r    <= act_val_nxt_s;
            act_en_r     <= act_en_nxt_s;
            sel_r        <= sel_nxt_s;
            gate_r       <= gate_nxt_s;
            frame_done_r <= frame_done_nxt_s;
        end
    end

    // The decoder tracks the current digit; BLANK_CYCLES hides its latency
    assign nibble_s = act_val_r[{idx_r, 2'b00} +: 4];

    seg7_hex_decode u_decode (
        .i_Clk    (i_Clk),
        .i_Rst    (i_Rst),
        .nibble   (nibble_s),
        .segments (dec_seg_s)
    );

    assign o_Segments   = gate_r ? dec_seg_s : 7'h00;
    assign o_Digit_Sel  = sel_r;
    assign o_Frame_Done = frame_done_r;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: directed scenarios plus random loads,
// checked every clock against a frame-arithmetic model of the display.
module tb_seven_seg_scan_ctrl;

    logic        i_Clk;
    logic        i_Rst;
    logic [15:0] i_Digits;
    logic [3:0]  i_Digit_En;
    logic        i_Load;
    logic [6:0]  o_Segments;
    logic [3:0]  o_Digit_Sel;
    logic        o_Frame_Done;

    int tests = 0;
    int fails = 0;

    // model state: cycle number since reset release plus displayed/pending values
    int          t_m;
    logic [15:0] act_v, pend_v;
    logic [3:0]  act_e, pend_e;
    bit          pend_ok;
    logic [3:0]  prev_sel;

    logic [6:0] lut [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                             7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    seven_seg_scan_ctrl #(
        .NUM_DIGITS     (4),
        .CLKS_PER_DIGIT (8),
        .BLANK_CYCLES   (2)
    ) dut (
        .i_Clk        (i_Clk),
        .i_Rst        (i_Rst),
        .i_Digits     (i_Digits),
        .i_Digit_En   (i_Digit_En),
        .i_Load       (i_Load),
        .o_Segments   (o_Segments),
        .o_Digit_Sel  (o_Digit_Sel),
        .o_Frame_Done (o_Frame_Done)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s t=%0d: observed %0h expected %0h", tag, t_m, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int          cnt   = t_m % 8;
        int          idx   = (t_m / 8) % 4;
        logic [3:0]  e_sel = 4'b0000;
        logic [6:0]  e_seg = 7'h00;
        logic [15:0] v     = act_v;
        if (cnt >= 2) begin
            e_sel = 4'b0001 << idx;
            if (act_e[idx]) e_seg = lut[v[idx*4 +: 4]];
        end
        check("sel", 32'(o_Digit_Sel), 32'(e_sel));
        check("seg", 32'(o_Segments), 32'(e_seg));
        check("frame_done", 32'(o_Frame_Done), 32'((t_m % 32) == 31));
        check("sel_onehot", 32'($countones(o_Digit_Sel) <= 1), 32'd1);
        check("sel_via_zero", 32'(prev_sel == 4'b0000 || o_Digit_Sel == 4'b0000 ||
                                  o_Digit_Sel == prev_sel), 32'd1);
        prev_sel = o_Digit_Sel;
    endtask

    task automatic step(input logic ld, input logic [15:0] dig, input logic [3:0] en);
        i_Load     = ld;
        i_Digits   = dig;
        i_Digit_En = en;
        @(posedge i_Clk);
        if ((t_m % 32) == 31) begin
            if (ld) begin
                act_v = dig; act_e = en; pend_ok = 1'b0;
            end else if (pend_ok) begin
                act_v = pend_v; act_e = pend_e; pend_ok = 1'b0;
            end
        end else if (ld) begin
            pend_v = dig; pend_e = en; pend_ok = 1'b1;
        end
        t_m++;
        #1;
        i_Load = 1'b0;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, i_Digits, i_Digit_En);
    endtask

    task automatic idle_until(input int phase);
        for (int i = 0; i < 64 && (t_m % 32) != phase; i++) step(1'b0, i_Digits, i_Digit_En);
    endtask

    task automatic do_reset();
        i_Rst  = 1'b1;
        i_Load = 1'b0;
        @(posedge i_Clk);
        #1;
        check("rst_seg", 32'(o_Segments), 32'h0);
        check("rst_sel", 32'(o_Digit_Sel), 32'h0);
        check("rst_frame_done", 32'(o_Frame_Done), 32'h0);
        @(posedge i_Clk);
        #2;
        i_Rst    = 1'b0;
        t_m      = 0;
        act_v    = 16'h0000; act_e  = 4'h0;
        pend_v   = 16'h0000; pend_e = 4'h0;
        pend_ok  = 1'b0;
        prev_sel = 4'h0;
        #1;
        check_outputs();
    endtask

    initial begin
        i_Rst      = 1'b1;
        i_Digits   = 16'h0000;
        i_Digit_En = 4'h0;
        i_Load     = 1'b0;
        t_m        = 0;

        // Reset with no load: dark for three frames, frame pulse at 31/63/95
        do_reset();
        idle(96);

        // Mid-frame load of 3A1F, shown from the following frame
        idle_until(12);
        step(1'b1, 16'h3A1F, 4'hF);
        idle(60);

        // Double load in one frame: the later value wins
        idle_until(5);
        step(1'b1, 16'h1111, 4'hF);
        idle(6);
        step(1'b1, 16'h2222, 4'hF);
        idle(60);

        // Load on the frame-done cycle commits straight into the next frame
        idle_until(31);
        step(1'b1, 16'h0008, 4'b0001);
        idle(40);

        // Asynchronous reset in the middle of digit 2's SHOW phase
        step(1'b1, 16'h5678, 4'hF);
        idle_until(20);
        idle_until(20);
        #1;
        i_Rst = 1'b1;
        #1;
        check("async_rst_sel", 32'(o_Digit_Sel), 32'h0);
        check("async_rst_seg", 32'(o_Segments), 32'h0);
        check("async_rst_frame_done", 32'(o_Frame_Done), 32'h0);
        do_reset();
        idle(40);

        // Every nibble value through digit 0
        for (int v = 0; v < 16; v++) begin
            step(1'b1, {16'($urandom) & 16'hFFF0} | 16'(v), 4'($urandom) | 4'b0001);
            idle(32);
        end

        // Random loads at random points in the frame
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0, 16'($urandom), 4'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
